vram_slot_ctrl: RTL and testbench

Parametrised time-slot controller for the video RAM. It multiplexes one single-port synchronous VRAM between NCH display fetch channels (playfield, motion-object link, alpha) and the 68k CPU port. Each display channel gets a fixed slot in a sequence started by the horizontal timing strobe. The CPU gets a trailing slot, or free access while the sequencer is idle (e.g. during blanking). The block also contains the playfield vertical scroll counter, generalised to SCRW bits.

---
 rtl/vram_slot_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_vram_slot_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_slot_ctrl.sv
// Time-slot arbiter for the single-port video RAM. It serves NCH display fetch
// channels and the 68k CPU port, and holds the playfield vertical scroll counter.

module vram_slot_lane #(
    parameter int DW   = 16,
    parameter int CW   = 2,
    parameter int LANE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          v1,
    input  logic [CW-1:0] ch1,
    input  logic          v2,
    input  logic [CW-1:0] ch2,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] data,
    output logic          valid
);
    localparam logic [CW-1:0] ID = CW'(LANE);

    // Data is captured when the returning word belongs to this lane.
    // The capture then holds until the next fetch for the same lane.
    always_ff @(posedge clk) begin
        if (rst)
            data <= '0;
        else if (v1 && ch1 == ID)
            data <= rdata;
    end

    assign valid = v2 && (ch2 == ID);
endmodule

module vram_slot_ctrl #(
    parameter int AW              = 12,
    parameter int DW              = 16,
    parameter int NCH             = 3,
    parameter int SLOTS           = 4,
    parameter int SCRW            = 9,
    parameter int CPU_IDLE_ACCESS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                slot_start,
    input  logic [NCH*AW-1:0]   ch_addr,
    output logic [NCH*DW-1:0]   ch_data,
    output logic [NCH-1:0]      ch_valid,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [DW/8-1:0]     cpu_be,
    input  logic [AW-1:0]       cpu_addr,
    input  logic [DW-1:0]       cpu_wdata,
    output logic [DW-1:0]       cpu_rdata,
    output logic                cpu_ack,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_we,
    output logic [DW/8-1:0]     mem_be,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    input  logic                vscrl_ld,
    input  logic [SCRW-1:0]     vscrl_val,
    input  logic                line_adv,
    output logic [SCRW-1:0]     pfv,
    output logic                seq_overrun
);
    localparam int SW     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int STAGES = 2;
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);
    localparam logic [SW-1:0] CPU_SLOT  = SW'(NCH);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    typedef struct packed {
        logic          cpu;
        logic [CW-1:0] ch;
    } tag_t;

    state_t                  state;
    logic [SW-1:0]           slot;
    logic                    cpu_out;
    logic                    cpu_seq_done;
    logic                    wr_ack_q;
    logic [STAGES:1]         vld_pipe;
    tag_t [STAGES:1]         tag_pipe;
    logic                    ch_issue;
    logic                    cpu_issue;
    logic [CW-1:0]           ch_sel;
    logic [NCH-1:0][AW-1:0]  ch_addr_a;
    logic [NCH-1:0][DW-1:0]  ch_data_a;

    assign ch_addr_a = ch_addr;
    assign ch_data   = ch_data_a;

    // Slot decode and VRAM port mux. Nothing is issued while rst is high, so
    // reset cycles present an inactive VRAM port.
    always_comb begin
        ch_issue  = 1'b0;
        cpu_issue = 1'b0;
        ch_sel    = slot[CW-1:0];
        if (!rst) begin
            if (state == S_RUN) begin
                if (slot < CPU_SLOT)
                    ch_issue = 1'b1;
                else
                    cpu_issue = cpu_req && !cpu_out && !cpu_seq_done;
            end else begin
                cpu_issue = (CPU_IDLE_ACCESS != 0) && cpu_req && !cpu_out && !slot_start;
            end
        end

        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        if (ch_issue) begin
            mem_addr = ch_addr_a[ch_sel];
        end else if (cpu_issue) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_be    = cpu_we ? cpu_be : '0;
            mem_wdata = cpu_we ? cpu_wdata : '0;
        end
    end

    // A slot_start that arrives during RUN is only flagged. It is never queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            slot         <= '0;
            cpu_seq_done <= 1'b0;
            seq_overrun  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (slot_start) begin
                        state        <= S_RUN;
                        slot         <= '0;
                        cpu_seq_done <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (slot_start)
                        seq_overrun <= 1'b1;
                    if (cpu_issue)
                        cpu_seq_done <= 1'b1;
                    if (slot == LAST_SLOT) begin
                        state <= S_IDLE;
                        slot  <= '0;
                    end else begin
                        slot <= slot + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read data is routed by the tag that was issued with the address.
    // Stage 1 covers the RAM access cycle. Stage 2 is the output cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            tag_pipe  <= '0;
            wr_ack_q  <= 1'b0;
            cpu_out   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            vld_pipe[1]     <= ch_issue || (cpu_issue && !cpu_we);
            tag_pipe[1].cpu <= cpu_issue;
            tag_pipe[1].ch  <= ch_sel;
            vld_pipe[2]     <= vld_pipe[1];
            tag_pipe[2]     <= tag_pipe[1];
            wr_ack_q        <= cpu_issue && cpu_we;
            if (vld_pipe[1] && tag_pipe[1].cpu)
                cpu_rdata <= mem_rdata;
            if (cpu_issue)
                cpu_out <= 1'b1;
            else if (cpu_ack)
                cpu_out <= 1'b0;
        end
    end

    assign cpu_ack = wr_ack_q | (vld_pipe[2] & tag_pipe[2].cpu);

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        vram_slot_lane #(.DW(DW), .CW(CW), .LANE(k)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .v1    (vld_pipe[1] & ~tag_pipe[1].cpu),
            .ch1   (tag_pipe[1].ch),
            .v2    (vld_pipe[2] & ~tag_pipe[2].cpu),
            .ch2   (tag_pipe[2].ch),
            .rdata (mem_rdata),
            .data  (ch_data_a[k]),
            .valid (ch_valid[k])
        );
    end

    // A load takes priority over a line advance in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)
            pfv <= '0;
        else if (vscrl_ld)
            pfv <= vscrl_val;
        else if (line_adv)
            pfv <= pfv + 1'b1;
    end
endmodule

// File: tb/tb_vram_slot_ctrl.sv
// Bench for vram_slot_ctrl: directed scenarios followed by random traffic,
// all checked against a cycle-indexed event model with a shadow RAM.

module tb_vram_slot_ctrl;
    localparam int AW = 12, DW = 16, NCH = 3, SLOTS = 4, SCRW = 9;
    localparam int BW = DW / 8;

    logic                clk = 1'b0;
    logic                rst, slot_start, cpu_req, cpu_we, vscrl_ld, line_adv;
    logic [NCH*AW-1:0]   ch_addr;
    logic [NCH*DW-1:0]   ch_data;
    logic [NCH-1:0]      ch_valid;
    logic [BW-1:0]       cpu_be, mem_be;
    logic [AW-1:0]       cpu_addr, mem_addr;
    logic [DW-1:0]       cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
    logic                cpu_ack, mem_we, seq_overrun;
    logic [SCRW-1:0]     vscrl_val, pfv;

    always #5 clk = ~clk;

    vram_slot_ctrl #(.AW(AW), .DW(DW), .NCH(NCH), .SLOTS(SLOTS), .SCRW(SCRW),
                     .CPU_IDLE_ACCESS(1)) dut (
        .clk(clk), .rst(rst), .slot_start(slot_start), .ch_addr(ch_addr),
        .ch_data(ch_data), .ch_valid(ch_valid), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .vscrl_ld(vscrl_ld), .vscrl_val(vscrl_val),
        .line_adv(line_adv), .pfv(pfv), .seq_overrun(seq_overrun)
    );

    // Synchronous VRAM with a one-cycle read latency. Its contents start as a ^ 0xA5A5.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    bit            ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int a = 0; a < (1<<AW); a++) ram[a] <= a[DW-1:0] ^ 16'hA5A5;
            ram_init <= 1'b1;
        end else if (mem_we) begin
            for (int b = 0; b < BW; b++)
                if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        int            due;
        int            ch;     // >=0 channel, -1 cpu read, -2 cpu write
        logic [DW-1:0] data;
    } ev_t;

    logic [DW-1:0]          shadow [0:(1<<AW)-1];
    ev_t                    evq[$];
    bit                     m_run, m_done, m_ovr, last_ack;
    int                     m_slot, m_busy_until, cyc;
    logic [SCRW-1:0]        m_pfv;
    logic [NCH-1:0][DW-1:0] m_chd;
    logic [DW-1:0]          m_rdata;
    int                     n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        evq.delete();
        m_run = 0; m_done = 0; m_ovr = 0; m_slot = 0; m_busy_until = -1;
        m_pfv = '0; m_chd = '0; m_rdata = '0;
    endtask

    // One clock cycle: check the DUT against the model, then advance the model.
    task automatic tick();
        logic [NCH-1:0]         e_v;
        bit                     e_ack, e_rd, ch_iss, cpu_iss;
        int                     ch_k;
        logic [AW-1:0]          e_addr;
        bit                     e_we;
        logic [BW-1:0]          e_be;
        logic [DW-1:0]          e_wd;
        logic [NCH-1:0][AW-1:0] ca;
        ev_t                    ev;
        #1;
        e_v = '0; e_ack = 0; e_rd = 0;
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].due == cyc) begin
                if (evq[i].ch >= 0) begin
                    e_v[evq[i].ch] = 1'b1;
                    m_chd[evq[i].ch] = evq[i].data;
                end else begin
                    e_ack = 1;
                    if (evq[i].ch == -1) begin e_rd = 1; m_rdata = evq[i].data; end
                end
                evq.delete(i);
            end
        end

        ca = ch_addr;
        ch_iss = 0; cpu_iss = 0; ch_k = 0;
        if (!rst) begin
            if (m_run && m_slot < NCH) begin
                ch_iss = 1; ch_k = m_slot;
            end else if (m_run) begin
                cpu_iss = cpu_req && cyc > m_busy_until && !m_done;
            end else begin
                cpu_iss = cpu_req && cyc > m_busy_until && !slot_start;
            end
        end
        e_addr = '0; e_we = 0; e_be = '0; e_wd = '0;
        if (ch_iss) e_addr = ca[ch_k];
        else if (cpu_iss) begin
            e_addr = cpu_addr; e_we = cpu_we; e_wd = cpu_wdata;
            e_be = cpu_we ? cpu_be : '0;
        end

        chk("mem_addr", 64'(mem_addr), 64'(e_addr));
        chk("mem_we", 64'(mem_we), 64'(e_we));
        chk("mem_be", 64'(mem_be), 64'(e_be));
        if (e_we) chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
        chk("ch_valid", 64'(ch_valid), 64'(e_v));
        chk("ch_data", 64'(ch_data), 64'(m_chd));
        chk("cpu_ack", 64'(cpu_ack), 64'(e_ack));
        if (e_rd) chk("cpu_rdata", 64'(cpu_rdata), 64'(m_rdata));
        chk("pfv", 64'(pfv), 64'(m_pfv));
        chk("seq_overrun", 64'(seq_overrun), 64'(m_ovr));

        last_ack = e_ack;
        if (rst) begin
            model_reset();
        end else begin
            if (cpu_iss && cpu_we) begin
                for (int b = 0; b < BW; b++)
                    if (cpu_be[b]) shadow[cpu_addr][b*8 +: 8] = cpu_wdata[b*8 +: 8];
                ev.due = cyc + 1; ev.ch = -2; ev.data = '0;
                evq.push_back(ev);
                m_busy_until = cyc + 1;
            end else if (cpu_iss) begin
                ev.due = cyc + 2; ev.ch = -1; ev.data = shadow[cpu_addr];
                evq.push_back(ev);
                m_busy_until = cyc + 2;
            end
            if (ch_iss) begin
                ev.due = cyc + 2; ev.ch = ch_k; ev.data = shadow[ca[ch_k]];
                evq.push_back(ev);
            end
            if (m_run) begin
                if (slot_start) m_ovr = 1;
                if (cpu_iss) m_done = 1;
                m_slot++;
                if (m_slot == SLOTS) m_run = 0;
            end else if (slot_start) begin
                m_run = 1; m_slot = 0; m_done = 0;
            end
            if (vscrl_ld) m_pfv = vscrl_val;
            else if (line_adv) m_pfv = SCRW'((int'(m_pfv) + 1) % (1 << SCRW));
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    bit req_act;

    initial begin
        for (int a = 0; a < (1<<AW); a++) shadow[a] = a[DW-1:0] ^ 16'hA5A5;
        rst = 1; slot_start = 0; cpu_req = 0; cpu_we = 0; cpu_be = '0;
        cpu_addr = '0; cpu_wdata = '0; vscrl_ld = 0; vscrl_val = '0; line_adv = 0;
        ch_addr = {12'h300, 12'h200, 12'h100};
        repeat (2) @(posedge clk);
        #1;
        model_reset(); cyc = 0; last_ack = 0;
        rst = 0;

        // Fetch sequence with a CPU byte write landing in the trailing slot
        slot_start = 1;
        #1;
        chk("rst_ch_valid", 64'(ch_valid), 64'h0);
        chk("rst_cpu_ack", 64'(cpu_ack), 64'h0);
        chk("rst_pfv", 64'(pfv), 64'h0);
        chk("rst_ch_data", 64'(ch_data), 64'h0);
        tick();
        slot_start = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'hABC; cpu_wdata = 16'h1234; cpu_be = 2'b01;
        #1; chk("seq_a0", 64'(mem_addr), 64'h100); chk("seq_we0", 64'(mem_we), 64'h0);
        tick();
        #1; chk("seq_a1", 64'(mem_addr), 64'h200);
        tick();
        #1; chk("seq_a2", 64'(mem_addr), 64'h300);
        chk("chv0", 64'(ch_valid), 64'h1); chk("chd0", 64'(ch_data[15:0]), 64'hA4A5);
        tick();
        #1; chk("wr_we", 64'(mem_we), 64'h1); chk("wr_addr", 64'(mem_addr), 64'hABC);
        chk("wr_be", 64'(mem_be), 64'h1);
        chk("chv1", 64'(ch_valid), 64'h2); chk("chd1", 64'(ch_data[31:16]), 64'hA7A5);
        tick();
        #1; chk("wr_ack", 64'(cpu_ack), 64'h1);
        chk("chv2", 64'(ch_valid), 64'h4); chk("chd2", 64'(ch_data[47:32]), 64'hA6A5);
        tick();

        // Idle read issues in the request cycle
        cpu_we = 0;
        #1; chk("idle_rd_addr", 64'(mem_addr), 64'hABC);
        tick();
        tick();
        #1; chk("idle_rd_ack", 64'(cpu_ack), 64'h1); chk("rd_merge", 64'(cpu_rdata), 64'hAF34);
        tick();

        // slot_start beats a coincident CPU request; overrun at slot 2
        cpu_addr = 12'h010; slot_start = 1;
        #1; chk("start_wins", 64'(mem_addr), 64'h0);
        tick();
        slot_start = 0;
        tick();
        tick();
        slot_start = 1;
        tick();
        slot_start = 0;
        #1; chk("cpu_slot3", 64'(mem_addr), 64'h010); chk("ovr_set", 64'(seq_overrun), 64'h1);
        tick();
        #1; chk("seq_len", 64'(mem_addr), 64'h0);
        tick();
        #1; chk("slot_rd_ack", 64'(cpu_ack), 64'h1); chk("slot_rd", 64'(cpu_rdata), 64'hA5B5);
        tick();
        cpu_req = 0;
        #1; chk("ovr_sticky", 64'(seq_overrun), 64'h1);
        tick();

        // Reset kills an in-flight channel 1 read. The held request is served afterwards.
        slot_start = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 12'h020;
        tick();
        slot_start = 0;
        tick();
        tick();
        rst = 1;
        tick();
        #1; chk("rst_chv1", 64'(ch_valid), 64'h0); chk("rst_maddr", 64'(mem_addr), 64'h0);
        chk("rst_ack", 64'(cpu_ack), 64'h0); chk("rst_ovr", 64'(seq_overrun), 64'h0);
        chk("rst_chd", 64'(ch_data), 64'h0);
        tick();
        rst = 0;
        #1; chk("post_rst_addr", 64'(mem_addr), 64'h020);
        tick();
        tick();
        #1; chk("post_rst_ack", 64'(cpu_ack), 64'h1); chk("post_rst_rd", 64'(cpu_rdata), 64'hA585);
        tick();

        // Scroll counter wrap and load priority
        cpu_req = 0; vscrl_ld = 1; vscrl_val = 9'h1FF;
        tick();
        vscrl_ld = 0; line_adv = 1;
        #1; chk("pfv_ld", 64'(pfv), 64'h1FF);
        tick();
        line_adv = 1; vscrl_ld = 1; vscrl_val = 9'h055;
        #1; chk("pfv_wrap", 64'(pfv), 64'h000);
        tick();
        vscrl_ld = 0; line_adv = 0;
        #1; chk("pfv_ld_pri", 64'(pfv), 64'h055);
        tick();

        // Random traffic
        req_act = 0; last_ack = 0;
        for (int n = 0; n < 3000; n++) begin
            if (req_act && last_ack) req_act = 0;
            if (!req_act && $urandom_range(3) == 0) begin
                req_act   = 1;
                cpu_we    = 1'($urandom_range(1));
                cpu_addr  = AW'($urandom_range(31));
                cpu_be    = BW'($urandom_range(3));
                cpu_wdata = DW'($urandom);
            end
            cpu_req    = req_act;
            slot_start = ($urandom_range(5) == 0);
            for (int k = 0; k < NCH; k++) ch_addr[k*AW +: AW] = AW'($urandom_range(31));
            vscrl_ld   = ($urandom_range(7) == 0);
            vscrl_val  = SCRW'($urandom);
            line_adv   = 1'($urandom_range(1));
            rst        = ($urandom_range(99) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule
